aemb2_pipe_ctl: RTL and testbench

Parametrised system signal controller for the AEMB2 core. It generates the global clock, a stretched synchronous reset, and the instruction-side and data-side pipeline enables from a configurable set of feedback sources. It advances an N-thread phase index and provides a halt/drain handshake. A stall watchdog flags stalls that do not resolve. It sits at the top of the core, between the system pins and every pipeline stage.

---
 rtl/aemb2_pipe_ctl.sv | 130 +++++++++++++
 tb/tb_aemb2_pipe_ctl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/aemb2_pipe_ctl.sv
// AEMB2 system signal controller: global clock, stretched reset, pipeline
// enables gated by masked feedback, thread phase, halt/drain handshake, stall watchdog.
module aemb2_pipe_ctl #(
  parameter int              AEMB_HTX = 2,
  parameter int              TW       = 1,
  parameter int              FB_N     = 4,
  parameter logic [FB_N-1:0] IENA_MSK = '1,
  parameter logic [FB_N-1:0] DENA_MSK = '1,
  parameter int              RST_DLY  = 2,
  parameter int              DRN_CYC  = 3,
  parameter int              WDT_W    = 8
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic            sys_ena_i,
  input  logic [FB_N-1:0] fb_i,
  input  logic            hlt_req_i,
  output logic            gclk,
  output logic            grst,
  output logic [TW-1:0]   gpha,
  output logic            iena,
  output logic            dena,
  output logic            hlt_ack_o,
  output logic            stl_to_o
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [TW-1:0] PHA_LAST = TW'(AEMB_HTX - 1);
  localparam logic [3:0]    RST_LD   = 4'(RST_DLY);
  localparam logic [3:0]    DRN_LD   = 4'(DRN_CYC);

  state_e             state_q, state_d;
  logic [3:0]         rst_cnt_q, rst_cnt_d;
  logic [3:0]         drn_cnt_q, drn_cnt_d;
  logic [TW-1:0]      gpha_q, gpha_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;
  logic               grst_q, hlt_ack_q, stl_to_q;
  logic               irdy, drdy, run_en, active;

  // Unmasked sources are forced to 1, so an all-zero mask reads as ready.
  assign irdy   = &(fb_i | ~IENA_MSK);
  assign drdy   = &(fb_i | ~DENA_MSK);
  assign run_en = sys_ena_i & ~sys_rst_i;
  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  assign iena = (state_q == ST_RUN) & irdy & run_en;
  assign dena = active & drdy & run_en;

  assign gclk      = sys_clk_i;
  assign grst      = grst_q;
  assign gpha      = gpha_q;
  assign hlt_ack_o = hlt_ack_q;
  assign stl_to_o  = stl_to_q;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    drn_cnt_d = drn_cnt_q;
    unique case (state_q)
      ST_RST: begin
        rst_cnt_d = rst_cnt_q - 4'd1;
        if (rst_cnt_q <= 4'd1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (hlt_req_i) begin
          state_d   = ST_DRAIN;
          drn_cnt_d = DRN_LD;
        end
      end
      ST_DRAIN: begin
        // A withdrawn request aborts the drain without waiting for the count.
        if (!hlt_req_i) begin
          state_d = ST_RUN;
        end else if (dena) begin
          drn_cnt_d = drn_cnt_q - 4'd1;
          if (drn_cnt_q <= 4'd1) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!hlt_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    gpha_d = gpha_q;
    if (dena | grst_q) gpha_d = (gpha_q == PHA_LAST) ? '0 : gpha_q + 1'b1;
  end

  always_comb begin
    wdt_d = wdt_q;
    if (dena || state_d == ST_HALT) begin
      wdt_d = '0;
    end else if (active && sys_ena_i && !(&wdt_q)) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q   <= ST_RST;
      rst_cnt_q <= RST_LD;
      drn_cnt_q <= DRN_LD;
      gpha_q    <= '0;
      wdt_q     <= '0;
      grst_q    <= 1'b1;
      hlt_ack_q <= 1'b0;
      stl_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      drn_cnt_q <= drn_cnt_d;
      gpha_q    <= gpha_d;
      wdt_q     <= wdt_d;
      grst_q    <= (state_d == ST_RST);
      hlt_ack_q <= (state_d == ST_HALT);
      stl_to_q  <= &wdt_d;
    end
  end

endmodule

// File: tb/tb_aemb2_pipe_ctl.sv
// Directed bench for aemb2_pipe_ctl: 3 threads, split masks, RST_DLY=3,
// DRN_CYC=3, WDT_W=4, with hand-derived expectations per scenario.
module tb_aemb2_pipe_ctl;

  logic       sys_clk_i = 1'b0;
  logic       sys_rst_i;
  logic       sys_ena_i;
  logic [3:0] fb_i;
  logic       hlt_req_i;
  logic       gclk, grst, iena, dena, hlt_ack_o, stl_to_o;
  logic [1:0] gpha;

  int tests = 0;
  int fails = 0;
  int exp_pha = 0;

  aemb2_pipe_ctl #(
    .AEMB_HTX(3), .TW(2), .FB_N(4),
    .IENA_MSK(4'b0011), .DENA_MSK(4'b1100),
    .RST_DLY(3), .DRN_CYC(3), .WDT_W(4)
  ) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .sys_ena_i(sys_ena_i),
    .fb_i(fb_i), .hlt_req_i(hlt_req_i),
    .gclk(gclk), .grst(grst), .gpha(gpha), .iena(iena), .dena(dena),
    .hlt_ack_o(hlt_ack_o), .stl_to_o(stl_to_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  function automatic int nxt(int p);
    return (p + 1) % 3;
  endfunction

  task automatic test_reset();
    sys_rst_i = 1'b1; sys_ena_i = 1'b1; fb_i = 4'hF; hlt_req_i = 1'b0;
    repeat (5) tick();
    tests++; if (grst !== 1'b1) begin fails++; $display("FAIL rst_grst: got %b exp 1", grst); end
    tests++; if (gpha !== 2'd0) begin fails++; $display("FAIL rst_gpha: got %0d exp 0", gpha); end
    tests++; if ({iena, dena} !== 2'b00) begin fails++; $display("FAIL rst_ena: got %b exp 00", {iena, dena}); end
    tests++; if ({hlt_ack_o, stl_to_o} !== 2'b00) begin fails++; $display("FAIL rst_ack_stl: got %b exp 00", {hlt_ack_o, stl_to_o}); end
    tests++; if (gclk !== sys_clk_i) begin fails++; $display("FAIL rst_gclk: got %b exp %b", gclk, sys_clk_i); end
    sys_rst_i = 1'b0;
    // Three stretch edges advance the phase 1,2,0; grst falls after the third.
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++; if (grst !== (i < 3)) begin fails++; $display("FAIL stretch_grst[%0d]: got %b exp %b", i, grst, (i < 3)); end
      tests++; if (gpha !== 2'(i % 3)) begin fails++; $display("FAIL stretch_gpha[%0d]: got %0d exp %0d", i, gpha, i % 3); end
    end
    exp_pha = 0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) begin
      tests++; if ({iena, dena} !== 2'b11) begin fails++; $display("FAIL wrap_ena[%0d]: got %b exp 11", i, {iena, dena}); end
      tests++; if (gpha !== 2'(exp_pha)) begin fails++; $display("FAIL wrap_gpha[%0d]: got %0d exp %0d", i, gpha, exp_pha); end
      tick();
      exp_pha = nxt(exp_pha);
    end
  endtask

  task automatic test_masks();
    fb_i = 4'b1101; #1;
    tests++; if ({iena, dena} !== 2'b01) begin fails++; $display("FAIL mask_1101: got %b exp 01", {iena, dena}); end
    tick(); exp_pha = nxt(exp_pha);
    tests++; if (gpha !== 2'(exp_pha)) begin fails++; $display("FAIL mask_gpha_adv: got %0d exp %0d", gpha, exp_pha); end
    fb_i = 4'b0111; #1;
    tests++; if ({iena, dena} !== 2'b10) begin fails++; $display("FAIL mask_0111: got %b exp 10", {iena, dena}); end
    tick();
    tests++; if (gpha !== 2'(exp_pha)) begin fails++; $display("FAIL mask_gpha_hold: got %0d exp %0d", gpha, exp_pha); end
  endtask

  task automatic test_halt();
    fb_i = 4'hF; hlt_req_i = 1'b1; #1;
    tests++; if (iena !== 1'b1) begin fails++; $display("FAIL halt_iena_req: got %b exp 1", iena); end
    tick(); exp_pha = nxt(exp_pha);
    tests++; if ({iena, hlt_ack_o} !== 2'b00) begin fails++; $display("FAIL halt_drain_entry: got %b exp 00", {iena, hlt_ack_o}); end
    // dena alternates 0,1 so the third pulse lands in the sixth drain cycle.
    for (int i = 0; i < 6; i++) begin
      fb_i = (i % 2 == 0) ? 4'b0011 : 4'hF; #1;
      tests++; if ({iena, dena, hlt_ack_o} !== {1'b0, 1'(i % 2), 1'b0})
        begin fails++; $display("FAIL halt_drain[%0d]: got %b exp %b", i, {iena, dena, hlt_ack_o}, {1'b0, 1'(i % 2), 1'b0}); end
      tick();
      if (i % 2 == 1) exp_pha = nxt(exp_pha);
    end
    for (int i = 0; i < 3; i++) begin
      tests++; if ({hlt_ack_o, iena, dena} !== 3'b100) begin fails++; $display("FAIL halt_held[%0d]: got %b exp 100", i, {hlt_ack_o, iena, dena}); end
      tests++; if (gpha !== 2'(exp_pha)) begin fails++; $display("FAIL halt_gpha[%0d]: got %0d exp %0d", i, gpha, exp_pha); end
      if (i < 2) tick();
    end
    hlt_req_i = 1'b0;
    tick();
    tests++; if ({hlt_ack_o, iena, dena} !== 3'b011) begin fails++; $display("FAIL halt_release: got %b exp 011", {hlt_ack_o, iena, dena}); end
    // Request dropped mid-drain returns to RUN on the next edge.
    hlt_req_i = 1'b1;
    tick(); exp_pha = nxt(exp_pha);
    tests++; if ({iena, dena} !== 2'b01) begin fails++; $display("FAIL abort_drain: got %b exp 01", {iena, dena}); end
    hlt_req_i = 1'b0;
    tick(); exp_pha = nxt(exp_pha);
    tests++; if ({hlt_ack_o, iena, dena} !== 3'b011) begin fails++; $display("FAIL abort_run: got %b exp 011", {hlt_ack_o, iena, dena}); end
    tests++; if (gpha !== 2'(exp_pha)) begin fails++; $display("FAIL abort_gpha: got %0d exp %0d", gpha, exp_pha); end
  endtask

  task automatic test_watchdog();
    fb_i = 4'h0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      tests++; if (stl_to_o !== (i >= 15)) begin fails++; $display("FAIL wdt_count[%0d]: got %b exp %b", i, stl_to_o, (i >= 15)); end
    end
    tests++; if (gpha !== 2'(exp_pha)) begin fails++; $display("FAIL wdt_gpha_hold: got %0d exp %0d", gpha, exp_pha); end
    fb_i = 4'hF; #1;
    tests++; if ({dena, stl_to_o} !== 2'b11) begin fails++; $display("FAIL wdt_recover_same: got %b exp 11", {dena, stl_to_o}); end
    tick(); exp_pha = nxt(exp_pha);
    tests++; if (stl_to_o !== 1'b0) begin fails++; $display("FAIL wdt_clear: got %b exp 0", stl_to_o); end
    // sys_ena_i low freezes the count: 5 + 9 stalled cycles stay below 15.
    fb_i = 4'h0;
    repeat (5) tick();
    sys_ena_i = 1'b0; #1;
    tests++; if ({iena, dena} !== 2'b00) begin fails++; $display("FAIL wdt_ena_off: got %b exp 00", {iena, dena}); end
    repeat (20) tick();
    tests++; if (stl_to_o !== 1'b0) begin fails++; $display("FAIL wdt_frozen: got %b exp 0", stl_to_o); end
    sys_ena_i = 1'b1;
    repeat (9) tick();
    tests++; if (stl_to_o !== 1'b0) begin fails++; $display("FAIL wdt_14: got %b exp 0", stl_to_o); end
    tick();
    tests++; if (stl_to_o !== 1'b1) begin fails++; $display("FAIL wdt_15: got %b exp 1", stl_to_o); end
  endtask

  task automatic test_reset_mid_drain();
    hlt_req_i = 1'b1;
    tick();
    tests++; if ({iena, hlt_ack_o, stl_to_o} !== 3'b001) begin fails++; $display("FAIL mid_drain_pre: got %b exp 001", {iena, hlt_ack_o, stl_to_o}); end
    sys_rst_i = 1'b1;
    tick();
    tests++; if ({grst, hlt_ack_o, stl_to_o} !== 3'b100) begin fails++; $display("FAIL mid_drain_rst: got %b exp 100", {grst, hlt_ack_o, stl_to_o}); end
    tests++; if (gpha !== 2'd0) begin fails++; $display("FAIL mid_drain_gpha: got %0d exp 0", gpha); end
    tests++; if ({iena, dena} !== 2'b00) begin fails++; $display("FAIL mid_drain_ena: got %b exp 00", {iena, dena}); end
    sys_rst_i = 1'b0; hlt_req_i = 1'b0; fb_i = 4'hF;
    repeat (3) tick();
    tests++; if ({grst, iena, dena} !== 3'b011) begin fails++; $display("FAIL restart: got %b exp 011", {grst, iena, dena}); end
    tests++; if (gpha !== 2'd0) begin fails++; $display("FAIL restart_gpha: got %0d exp 0", gpha); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_masks();
    test_halt();
    test_watchdog();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
